// File: rtl/rdi_pm_pkg.sv
// Shared definitions for the RDI PM entry responder: RDI state encodings,
// PM request type codes and the responder FSM state enum.
package rdi_pm_pkg;

  localparam logic [3:0] ST_NOP    = 4'b0000;
  localparam logic [3:0] ST_ACTIVE = 4'b0001;
  localparam logic [3:0] ST_L1     = 4'b0100;
  localparam logic [3:0] ST_L2     = 4'b1000;

  localparam logic PM_TYPE_L1 = 1'b0;
  localparam logic PM_TYPE_L2 = 1'b1;

  typedef enum logic [2:0] {
    S_RESET,
    S_ACTIVE,
    S_SB_REQ,
    S_SB_WAIT,
    S_STALL,
    S_PM,
    S_EXIT
  } pm_state_e;

  // Status encoding reported once the latched PM target has been entered.
  function automatic logic [3:0] target_sts(input logic pm_type);
    return (pm_type == PM_TYPE_L2) ? ST_L2 : ST_L1;
  endfunction

endpackage

// File: rtl/pm_timeout_counter.sv
// Wait-state timeout counter for the RDI PM entry responder.
// Cleared on entry to a waiting state, counts while enabled, and flags
// expiry during the TIMEOUT_CYCLES-th cycle spent waiting.
module pm_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter; clear has priority so a fresh wait always starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_q <= '0;
    end else if (i_enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_expired = i_enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rdi_pm_entry_responder.sv
// RDI PM entry responder (physical-layer side).
// Accepts L1/L2 requests, negotiates over the sideband, runs the
// stallreq/stallack drain and reports the new state. All outputs registered.
// Optional wait-state timeout: define RDI_PM_ENTRY_TIMEOUT_EN.
module rdi_pm_entry_responder
  import rdi_pm_pkg::*;
#(
  parameter int unsigned STATE_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [STATE_W-1:0] i_lp_state_req,
  input  logic               i_lp_stallack,
  input  logic               i_sb_pm_ack,
  input  logic               i_sb_pm_nak,
  output logic               o_sb_pm_req_valid,
  output logic               o_sb_pm_req_type,
  output logic               o_pl_stallreq,
  output logic [STATE_W-1:0] o_pl_state_sts,
  output logic               o_pm_nak
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  pm_state_e          state_q, state_d;
  logic               target_q, target_d;
  logic [STATE_W-1:0] sts_q, sts_d;
  logic               stall_q, stall_d;
  logic               valid_q, valid_d;
  logic               type_q, type_d;
  logic               nak_q, nak_d;
  logic               timeout;

  logic req_active, req_l1, req_l2;
  assign req_active = (i_lp_state_req == STATE_W'(ST_ACTIVE));
  assign req_l1     = (i_lp_state_req == STATE_W'(ST_L1));
  assign req_l2     = (i_lp_state_req == STATE_W'(ST_L2));

`ifdef RDI_PM_ENTRY_TIMEOUT_EN
  logic cnt_clear, cnt_enable;
  assign cnt_clear  = (state_d != state_q) &&
                      ((state_d == S_SB_WAIT) || (state_d == S_STALL));
  assign cnt_enable = (state_q == S_SB_WAIT) || (state_q == S_STALL);

  pm_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (cnt_clear),
    .i_enable  (cnt_enable),
    .o_expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_RESET;
      target_q <= PM_TYPE_L1;
      sts_q    <= STATE_W'(ST_NOP);
      stall_q  <= 1'b0;
      valid_q  <= 1'b0;
      type_q   <= 1'b0;
      nak_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sts_q    <= sts_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
      type_q   <= type_d;
      nak_q    <= nak_d;
    end
  end

  // Next state plus next value of every output; pulses default low.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sts_d    = sts_q;
    stall_d  = stall_q;
    valid_d  = 1'b0;
    type_d   = type_q;
    nak_d    = 1'b0;
    unique case (state_q)
      S_RESET: begin
        if (req_active) begin
          state_d = S_ACTIVE;
          sts_d   = STATE_W'(ST_ACTIVE);
        end
      end
      S_ACTIVE: begin
        if (req_l1 || req_l2) begin
          target_d = req_l2 ? PM_TYPE_L2 : PM_TYPE_L1;
          valid_d  = 1'b1;
          type_d   = target_d;
          state_d  = S_SB_REQ;
        end
      end
      S_SB_REQ: begin
        state_d = S_SB_WAIT;
      end
      S_SB_WAIT: begin
        // Nak and abort beat ack; ack beats a coincident timeout.
        if (i_sb_pm_nak || req_active) begin
          nak_d   = 1'b1;
          state_d = S_ACTIVE;
        end else if (i_sb_pm_ack) begin
          stall_d = 1'b1;
          state_d = S_STALL;
        end else if (timeout) begin
          nak_d   = 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_STALL: begin
        if (i_lp_stallack) begin
          stall_d = 1'b0;
          sts_d   = STATE_W'(target_sts(target_q));
          state_d = S_PM;
        end else if (timeout) begin
          stall_d = 1'b0;
          nak_d   = 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_PM: begin
        if (req_active) begin
          state_d = S_EXIT;
        end
      end
      S_EXIT: begin
        sts_d   = STATE_W'(ST_ACTIVE);
        state_d = S_ACTIVE;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign o_sb_pm_req_valid = valid_q;
  assign o_sb_pm_req_type  = type_q;
  assign o_pl_stallreq     = stall_q;
  assign o_pl_state_sts    = sts_q;
  assign o_pm_nak          = nak_q;

endmodule

// File: tb/tb_rdi_pm_entry_responder.sv
// Self-checking bench for rdi_pm_entry_responder: directed scenarios followed
// by randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_rdi_pm_entry_responder;

  localparam int unsigned TO = 8;

  // Behavioural phases of the handshake.
  localparam int PH_RESET = 0, PH_ACTIVE = 1, PH_REQ = 2, PH_WAIT = 3,
                 PH_STALL = 4, PH_PM = 5, PH_EXIT = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       stallack, ack, nak;
  logic       req_valid, req_type, stallreq, pm_nak;
  logic [3:0] sts;

  int n_cmp = 0;
  int n_err = 0;

  // Model state.
  int         m_ph;
  int         m_tgt;
  int         m_wait;
  logic [3:0] m_sts;
  logic       m_stall, m_valid, m_type, m_nak;

  always #5 clk = ~clk;

  rdi_pm_entry_responder #(
    .STATE_W        (4),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_lp_state_req    (req),
    .i_lp_stallack     (stallack),
    .i_sb_pm_ack       (ack),
    .i_sb_pm_nak       (nak),
    .o_sb_pm_req_valid (req_valid),
    .o_sb_pm_req_type  (req_type),
    .o_pl_stallreq     (stallreq),
    .o_pl_state_sts    (sts),
    .o_pm_nak          (pm_nak)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // True when the timeout applies in the current waiting phase.
  function automatic bit timed_out();
`ifdef RDI_PM_ENTRY_TIMEOUT_EN
    return m_wait == int'(TO) - 1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_step(input logic [3:0] r, input logic a, input logic n,
                            input logic sa, input logic rs);
    m_valid = 1'b0;
    m_nak   = 1'b0;
    if (rs) begin
      m_ph = PH_RESET; m_sts = 4'h0; m_stall = 1'b0; m_type = 1'b0;
      return;
    end
    case (m_ph)
      PH_RESET: if (r == 4'h1) begin m_ph = PH_ACTIVE; m_sts = 4'h1; end
      PH_ACTIVE:
        if (r == 4'h4 || r == 4'h8) begin
          m_tgt = (r == 4'h8) ? 1 : 0;
          m_valid = 1'b1; m_type = 1'(m_tgt); m_ph = PH_REQ;
        end
      PH_REQ: begin m_ph = PH_WAIT; m_wait = 0; end
      PH_WAIT:
        if (n || r == 4'h1) begin m_nak = 1'b1; m_ph = PH_ACTIVE; end
        else if (a) begin m_stall = 1'b1; m_ph = PH_STALL; m_wait = 0; end
        else if (timed_out()) begin m_nak = 1'b1; m_ph = PH_ACTIVE; end
        else m_wait++;
      PH_STALL:
        if (sa) begin m_stall = 1'b0; m_sts = (m_tgt == 1) ? 4'h8 : 4'h4; m_ph = PH_PM; end
        else if (timed_out()) begin m_stall = 1'b0; m_nak = 1'b1; m_ph = PH_ACTIVE; end
        else m_wait++;
      PH_PM: if (r == 4'h1) m_ph = PH_EXIT;
      PH_EXIT: begin m_sts = 4'h1; m_ph = PH_ACTIVE; end
      default: m_ph = PH_RESET;
    endcase
  endtask

  // One clock: drive on the falling edge, compare just after the rising edge.
  task automatic cyc(input logic [3:0] r, input logic a, input logic n,
                     input logic sa, input logic rs);
    @(negedge clk);
    req = r; ack = a; nak = n; stallack = sa; rst = rs;
    @(posedge clk);
    #1;
    model_step(r, a, n, sa, rs);
    check("sts", 32'(sts), 32'(m_sts));
    check("stallreq", 32'(stallreq), 32'(m_stall));
    check("req_valid", 32'(req_valid), 32'(m_valid));
    check("pm_nak", 32'(pm_nak), 32'(m_nak));
    if (m_valid) check("req_type", 32'(req_type), 32'(m_type));
  endtask

  int nak_seen;

  initial begin
    req = 4'h0; ack = 1'b0; nak = 1'b0; stallack = 1'b0; rst = 1'b1;
    m_ph = PH_RESET; m_tgt = 0; m_wait = 0; m_sts = 4'h0;
    m_stall = 1'b0; m_valid = 1'b0; m_type = 1'b0; m_nak = 1'b0;

    // Reset values.
    cyc(4'h0, 0, 0, 0, 1);
    cyc(4'h0, 0, 0, 0, 1);
    check("rst_sts", 32'(sts), 32'h0);
    check("rst_type", 32'(req_type), 32'h0);

    // Happy path into L1 and back out.
    cyc(4'h1, 0, 0, 0, 0);
    check("act_sts", 32'(sts), 32'h1);
    cyc(4'h4, 0, 0, 0, 0);
    check("l1_valid", 32'(req_valid), 32'h1);
    check("l1_type", 32'(req_type), 32'h0);
    cyc(4'h4, 0, 0, 0, 0);
    check("l1_valid_pulse", 32'(req_valid), 32'h0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 1, 0);   // stallack outside STALL is ignored
    cyc(4'h4, 1, 0, 0, 0);
    check("ack_stall", 32'(stallreq), 32'h1);
    cyc(4'h8, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 1, 0);
    check("pm_sts", 32'(sts), 32'h4);
    check("pm_stall_drop", 32'(stallreq), 32'h0);
    cyc(4'h8, 0, 0, 0, 0);   // L1->L2 ignored
    cyc(4'h1, 0, 0, 0, 0);
    check("exit_hold", 32'(sts), 32'h4);
    cyc(4'h1, 0, 0, 0, 0);
    check("exit_sts", 32'(sts), 32'h1);

    // NAK for an L2 request.
    cyc(4'h8, 0, 0, 0, 0);
    check("l2_type", 32'(req_type), 32'h1);
    cyc(4'h8, 0, 0, 0, 0);
    cyc(4'h8, 0, 1, 0, 0);
    check("nak_pulse", 32'(pm_nak), 32'h1);
    check("nak_sts", 32'(sts), 32'h1);
    cyc(4'h0, 0, 0, 0, 0);

    // Simultaneous ack and nak.
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 1, 1, 0, 0);
    check("both_nak", 32'(pm_nak), 32'h1);
    check("both_nostall", 32'(stallreq), 32'h0);

    // Abort then late ack.
    cyc(4'h8, 0, 0, 0, 0);
    cyc(4'h8, 0, 0, 0, 0);
    cyc(4'h1, 0, 0, 0, 0);
    check("abort_nak", 32'(pm_nak), 32'h1);
    cyc(4'h0, 1, 0, 0, 0);
    check("late_ack", 32'(stallreq), 32'h0);
    check("abort_sts", 32'(sts), 32'h1);

    // Stall with no stallack.
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 1, 0, 0, 0);
    nak_seen = 0;
`ifdef RDI_PM_ENTRY_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      cyc(4'h4, 0, 0, 0, 0);
      if (pm_nak) nak_seen++;
    end
    check("to_stall_drop", 32'(stallreq), 32'h0);
    check("to_nak_once", 32'(nak_seen), 32'h1);
    check("to_sts", 32'(sts), 32'h1);
`else
    for (int i = 0; i < 100; i++) begin
      cyc(4'h4, 0, 0, 0, 0);
      if (pm_nak) nak_seen++;
    end
    check("noto_stall_held", 32'(stallreq), 32'h1);
    check("noto_no_nak", 32'(nak_seen), 32'h0);
`endif

    // Reset during STALL.
    cyc(4'h1, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 1, 0, 0, 0);
    check("pre_rst_stall", 32'(stallreq), 32'h1);
    cyc(4'h4, 0, 0, 0, 1);
    check("mid_rst_stall", 32'(stallreq), 32'h0);
    check("mid_rst_sts", 32'(sts), 32'h0);

    // L1 entry and exit after the mid-operation reset.
    cyc(4'h1, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 0, 0, 0, 0);
    cyc(4'h4, 1, 0, 0, 0);
    cyc(4'h4, 0, 0, 1, 0);
    check("re_pm_sts", 32'(sts), 32'h4);
    cyc(4'h1, 0, 0, 0, 0);
    cyc(4'h1, 0, 0, 0, 0);
    check("re_exit_sts", 32'(sts), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      logic a, n, sa, rs;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r = req;
        4:          r = 4'h0;
        5, 9:       r = 4'h1;
        6:          r = 4'h4;
        7:          r = 4'h8;
        default:    r = 4'($urandom_range(0, 15));
      endcase
      // Ack is not offered together with an abort request.
      a  = ($urandom_range(0, 6) == 0) && (r != 4'h1);
      n  = ($urandom_range(0, 19) == 0);
      sa = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cyc(r, a, n, sa, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
